// File: rtl/feature_loader_pkg.sv
// -----------------------------------------------------------------------------
// feature_loader_pkg
//
// Purpose:
//   Shared definitions for the feature loader:
//     - state_t     : loader FSM states (LOAD, START, HOLD).
//     - slot_offset : bit offset of feature slot i inside the packed frame.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package feature_loader_pkg;

  // LOAD  : collecting features from the serial input.
  // START : one-cycle restart pulse for the downstream network.
  // HOLD  : waiting for the downstream prediction to settle.
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Feature i occupies bits [i*feat_bits +: feat_bits] of the frame.
  function automatic int slot_offset(input int slot, input int feat_bits);
    return slot * feat_bits;
  endfunction

endpackage

// File: rtl/feature_loader.sv
// -----------------------------------------------------------------------------
// feature_loader
//
// Purpose:
//   Collects FEAT_CNT serial features into a parallel frame for a downstream
//   classifier network, pulses start to restart that network, waits
//   RUN_CYCLES for the network to settle, then captures its prediction.
//
// Parameters:
//   FEAT_CNT   features per frame (>= 2)
//   FEAT_BITS  bits per feature
//   RUN_CYCLES cycles from start to a stable prediction (>= 1)
//   PRED_BITS  prediction width
//
// Ports:
//   clk           in   1                     rising-edge clock
//   rst           in   1                     synchronous active-high reset
//   in_valid      in   1                     in_data holds a valid feature
//   in_data       in   FEAT_BITS             one feature, feature 0 first
//   in_ready      out  1                     feature accepted this cycle
//   features      out  FEAT_CNT*FEAT_BITS    assembled frame
//   start         out  1                     one-cycle downstream restart
//   prediction    in   PRED_BITS             downstream winner
//   result        out  PRED_BITS             captured prediction
//   result_valid  out  1                     one-cycle pulse on result update
//
// Timing (last feature accepted at cycle T):
//   start at T+1, result_valid at T+RUN_CYCLES+2, in_ready low T+1..T+RUN_CYCLES+1.
// -----------------------------------------------------------------------------
module feature_loader
  import feature_loader_pkg::*;
#(
  parameter int FEAT_CNT   = 4,
  parameter int FEAT_BITS  = 4,
  parameter int RUN_CYCLES = 8,
  parameter int PRED_BITS  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [FEAT_BITS-1:0]          in_data,
  output logic                          in_ready,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  output logic                          start,
  input  logic [PRED_BITS-1:0]          prediction,
  output logic [PRED_BITS-1:0]          result,
  output logic                          result_valid
);

  localparam int IDX_W = $clog2(FEAT_CNT);
  localparam int CNT_W = $clog2(RUN_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEAT_CNT - 1);
  localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(RUN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     count;
  logic [FEAT_BITS-1:0] slots [FEAT_CNT];
  logic                 transfer;

  // Ready is gated by rst so nothing is acknowledged during a reset cycle;
  // the sender then holds its data until the first cycle out of reset.
  assign in_ready = (state == LOAD) && !rst;
  assign transfer = in_valid && in_ready;

  // Slots are kept as an unpacked array so each write touches one slot only;
  // untouched slots keep the previous frame's values.
  for (genvar g = 0; g < FEAT_CNT; g++) begin : g_frame
    assign features[slot_offset(g, FEAT_BITS) +: FEAT_BITS] = slots[g];
  end

  // Loader FSM with registered start/result_valid pulses. Both pulses default
  // low every cycle and are raised only on the transition that owns them, so
  // a reset in any state discards the partial frame without a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      idx          <= '0;
      count        <= '0;
      result       <= '0;
      start        <= 1'b0;
      result_valid <= 1'b0;
      for (int i = 0; i < FEAT_CNT; i++) begin
        slots[i] <= '0;
      end
    end else begin
      start        <= 1'b0;
      result_valid <= 1'b0;
      unique case (state)
        LOAD: begin
          if (transfer) begin
            slots[idx] <= in_data;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              start <= 1'b1;
              state <= START;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        START: begin
          count <= RUN_LOAD;
          state <= HOLD;
        end
        HOLD: begin
          count <= count - 1'b1;
          // Counter value 1 is the last settling cycle: the prediction is
          // stable now and LOAD reopens together with result_valid.
          if (count == CNT_ONE) begin
            result       <= prediction;
            result_valid <= 1'b1;
            state        <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: doc/feature_loader.md
FEATURE_LOADER -- requirements
Module: feature_loader

Interface
REQ-001 Parameter FEAT_CNT, default 4: number of features per frame; SHALL be >= 2.
REQ-002 Parameter FEAT_BITS, default 4: bits per feature.
REQ-003 Parameter RUN_CYCLES, default 8: cycles the downstream network needs from start to a stable prediction; SHALL be >= 1.
REQ-004 Parameter PRED_BITS, default 2: prediction width (equals $clog2(CLASS_CNT) of the consumer).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  in_data holds a valid feature.
REQ-008 in_data  input  FEAT_BITS  one feature, sent in order feature 0 first.
REQ-009 in_ready  output  1  block accepts a feature this cycle.
REQ-010 features  output  FEAT_CNT*FEAT_BITS  assembled frame; feature i at bits [i*FEAT_BITS +: FEAT_BITS].
REQ-011 start  output  1  one-cycle pulse that restarts the downstream network (drives its rst).
REQ-012 prediction  input  PRED_BITS  downstream winner.
REQ-013 result  output  PRED_BITS  captured prediction of the last frame.
REQ-014 result_valid  output  1  one-cycle pulse when result updates.

Function
REQ-015 FSM states SHALL be LOAD, START, HOLD.
REQ-016 LOAD: in_ready=1; a transfer occurs when in_valid&&in_ready; each transfer writes in_data into slot idx and increments idx.
REQ-017 Transfer with idx==FEAT_CNT-1: idx wraps to 0 and the next state is START.
REQ-018 START: lasts exactly 1 cycle; start=1 and in_ready=0; the hold counter loads RUN_CYCLES; the next state is HOLD.
REQ-019 HOLD: in_ready=0; features stays constant; the counter decrements each cycle.
REQ-020 HOLD at counter==1: result<=prediction, result_valid=1 in the following cycle, and the next state is LOAD.
REQ-021 Latency: the last feature accepted at cycle T gives start at T+1 and result_valid at T+RUN_CYCLES+2.
REQ-022 in_valid during START/HOLD SHALL be ignored; no data is lost because in_ready=0 and the sender holds.
REQ-023 Back-to-back frames: LOAD SHALL accept a feature in the same cycle result_valid is high.
REQ-024 Gaps in in_valid during LOAD SHALL only stall idx; partial frames are retained indefinitely.
REQ-025 features SHALL change only on LOAD transfers; slots not yet rewritten keep the previous frame's values.
REQ-026 Counter width SHALL be $clog2(RUN_CYCLES+1); idx width SHALL be $clog2(FEAT_CNT); no other arithmetic is performed.

Reset
REQ-027 rst=1 at any state, including mid-frame or mid-HOLD, SHALL force the following in the next cycle: state=LOAD, idx=0, counter=0, features=0, result=0, start=0, result_valid=0.
REQ-028 in_ready SHALL be 0 while rst is asserted and 1 in the first cycle after rst deasserts.
REQ-029 A frame interrupted by reset SHALL NOT produce start or result_valid.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (LOAD/START/HOLD) and a slot-offset helper (i*FEAT_BITS).
REQ-031 Single flat module; no sub-module is required. The parent ORs start with the system rst for the network instance.

Verification (FEAT_CNT=4, FEAT_BITS=4, RUN_CYCLES=6, PRED_BITS=2)
REQ-032 Send 1,2,3,4 on consecutive cycles -> features=16'h4321; start one cycle after the 4th; in_ready low 7 cycles.
REQ-033 Hold prediction=2'd3 -> result_valid exactly 8 cycles after the 4th transfer with result=3; result then holds.
REQ-034 in_valid toggled 1,0,0,1,1,0,1 with data A,x,x,B,C,x,D -> features=16'hDCBA; idx never advances on idle cycles.
REQ-035 rst pulsed after 2 features -> features=0, no start; next 4 features F,E,D,C -> features=16'hCDEF.
REQ-036 rst pulsed in HOLD cycle 3 -> no result_valid and result=0; a following frame completes normally.
REQ-037 Two frames streamed with in_valid=1 continuously -> second frame's first transfer coincides with result_valid; exactly 2 start pulses and 2 result_valid pulses.
